// File: rtl/morse_pkg.sv
// Shared types and defaults for the Morse symbol sequencer.
package morse_pkg;

    localparam int unsigned LEN_W              = 3;
    localparam int unsigned MAX_ELEMS          = 6;
    localparam int unsigned PAT_W              = MAX_ELEMS;
    localparam int unsigned DASH_UNITS_DEF     = 3;
    localparam int unsigned ELEM_GAP_UNITS_DEF = 1;
    localparam int unsigned CHAR_GAP_UNITS_DEF = 3;
    localparam int unsigned WORD_GAP_UNITS_DEF = 7;
    localparam int unsigned CNT_W_DEF          = 4;

    // Element count that encodes a word space
    localparam logic [LEN_W-1:0] LEN_WORD_SPACE = '0;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        MARK,
        EGAP,
        CGAP,
        WORD
    } state_t;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [PAT_W-1:0] pattern;
    } sym_t;

    // Out-of-range element counts collapse to the longest legal symbol
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len > LEN_W'(MAX_ELEMS)) begin
            return LEN_W'(MAX_ELEMS);
        end
        return len;
    endfunction

endpackage

// File: rtl/morse_symbol_sequencer_if.sv
// Symbol handshake between message source and sequencer.
interface morse_symbol_sequencer_if;

    logic              valid;
    logic              ready;
    morse_pkg::sym_t   sym;

    modport master (
        output valid,
        output sym,
        input  ready
    );

    modport slave (
        input  valid,
        input  sym,
        output ready
    );

endinterface

// File: rtl/morse_unit_timer.sv
// Counts unit ticks within a state; flags the tick that ends the duration.
module morse_unit_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] duration,
    output logic             expire_c
);

    logic [CNT_W-1:0] cnt_q;

    // Unit counter, restarted on every state entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Final tick of the programmed duration
    assign expire_c = tick && (cnt_q == (duration - CNT_W'(1)));

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Sequences one Morse symbol at a time onto the laser/LED keying outputs.
module morse_symbol_sequencer
    import morse_pkg::*;
#(
    parameter int unsigned DASH_UNITS     = DASH_UNITS_DEF,
    parameter int unsigned ELEM_GAP_UNITS = ELEM_GAP_UNITS_DEF,
    parameter int unsigned CHAR_GAP_UNITS = CHAR_GAP_UNITS_DEF,
    parameter int unsigned WORD_GAP_UNITS = WORD_GAP_UNITS_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     unit_tick,
    input  logic                     abort,
    morse_symbol_sequencer_if.slave  sym_if,
    output logic                     laser_on,
    output logic                     is_dash,
    output logic                     busy,
    output logic                     sym_done
);

    // Pattern padded to a power of two so any index value selects a real bit
    localparam int unsigned PAT_PAD_W = 2 ** LEN_W;

    state_t               state_q, state_n;
    logic [LEN_W-1:0]     len_q, len_n;
    logic [PAT_PAD_W-1:0] pat_q, pat_n;
    logic [LEN_W-1:0]     idx_q, idx_n;
    logic                 laser_n, dash_n, busy_n, done_n;
    logic [CNT_W-1:0]     dur_c;
    logic                 expire_c;
    logic                 accept_c;
    logic                 clear_c;

    assign sym_if.ready = reset_n && (state_q == IDLE) && !abort;
    assign accept_c     = sym_if.valid && sym_if.ready;
    assign clear_c      = (state_n != state_q);

    // Duration of the current state in units
    always_comb begin
        dur_c = CNT_W'(1);
        case (state_q)
            MARK:    dur_c = pat_q[idx_q] ? CNT_W'(DASH_UNITS) : CNT_W'(1);
            EGAP:    dur_c = CNT_W'(ELEM_GAP_UNITS);
            CGAP:    dur_c = CNT_W'(CHAR_GAP_UNITS);
            WORD:    dur_c = CNT_W'(WORD_GAP_UNITS - CHAR_GAP_UNITS);
            default: dur_c = CNT_W'(1);
        endcase
    end

    morse_unit_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear_c),
        .tick     (unit_tick),
        .duration (dur_c),
        .expire_c (expire_c)
    );

    // Next-state, symbol capture and next output values
    always_comb begin
        state_n = state_q;
        len_n   = len_q;
        pat_n   = pat_q;
        idx_n   = idx_q;
        done_n  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_n = ARM;
                    len_n   = clamp_len(sym_if.sym.len);
                    pat_n   = PAT_PAD_W'(sym_if.sym.pattern);
                    idx_n   = '0;
                end
            end
            ARM: begin
                // Align the first mark (or word space) to a unit boundary
                if (unit_tick) begin
                    state_n = (len_q == LEN_WORD_SPACE) ? WORD : MARK;
                end
            end
            MARK: begin
                if (expire_c) begin
                    state_n = ((idx_q + LEN_W'(1)) < len_q) ? EGAP : CGAP;
                end
            end
            EGAP: begin
                if (expire_c) begin
                    state_n = MARK;
                    idx_n   = idx_q + LEN_W'(1);
                end
            end
            CGAP, WORD: begin
                if (expire_c) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Flush wins over everything, and suppresses completion
        if (abort) begin
            state_n = IDLE;
            done_n  = 1'b0;
        end

        laser_n = (state_n == MARK);
        dash_n  = (state_n == MARK) && pat_n[idx_n];
        busy_n  = (state_n != IDLE);
    end

    // State, captured symbol and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            pat_q    <= '0;
            idx_q    <= '0;
            laser_on <= 1'b0;
            is_dash  <= 1'b0;
            busy     <= 1'b0;
            sym_done <= 1'b0;
        end else begin
            state_q  <= state_n;
            len_q    <= len_n;
            pat_q    <= pat_n;
            idx_q    <= idx_n;
            laser_on <= laser_n;
            is_dash  <= dash_n;
            busy     <= busy_n;
            sym_done <= done_n;
        end
    end

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Scoreboard bench: stimulus queues expected marks/completions, a monitor checks them.
module tb_morse_symbol_sequencer;
    import morse_pkg::*;

    localparam int K_MARK = 0;
    localparam int K_DONE = 1;

    typedef struct {
        int    kind;
        int    len;
        int    dash;
        int    gap;
        string name;
    } exp_t;

    logic clk;
    logic reset_n;
    logic unit_tick;
    logic abort;
    logic laser_on;
    logic is_dash;
    logic busy;
    logic sym_done;

    morse_symbol_sequencer_if sym_if();

    morse_symbol_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .unit_tick (unit_tick),
        .abort     (abort),
        .sym_if    (sym_if),
        .laser_on  (laser_on),
        .is_dash   (is_dash),
        .busy      (busy),
        .sym_done  (sym_done)
    );

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   viol = 0;
    int   last_done_cyc = -100;
    int   last_evt = 0;

    function automatic void chk(input string name, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    endfunction

    function automatic sym_t mk(input int l, input int p);
        sym_t s;
        s.len     = 3'(l);
        s.pattern = 6'(p);
        return s;
    endfunction

    function automatic void push_mark(input int len, input int dash, input int gap, input string name);
        exp_t e;
        e.kind = K_MARK; e.len = len; e.dash = dash; e.gap = gap; e.name = name;
        exp_q.push_back(e);
    endfunction

    function automatic void push_done(input int gap, input string name);
        exp_t e;
        e.kind = K_DONE; e.len = 0; e.dash = 0; e.gap = gap; e.name = name;
        exp_q.push_back(e);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Unit tick: one-cycle pulse every 10 clocks
    initial begin
        int tcnt;
        tcnt = 0;
        unit_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tcnt = (tcnt == 9) ? 0 : tcnt + 1;
            unit_tick = (tcnt == 9);
        end
    end

    // Monitor: measures each laser mark and each completion, checks against queue
    initial begin
        logic laser_prev;
        int   mark_len;
        int   mark_dash;
        int   rise_gap;
        exp_t e;
        laser_prev = 1'b0;
        mark_len = 0;
        mark_dash = 0;
        rise_gap = 0;
        forever begin
            @(negedge clk);
            if (laser_on && !laser_prev) begin
                rise_gap  = cyc - last_evt;
                mark_len  = 0;
                mark_dash = int'(is_dash);
            end
            if (laser_on) begin
                mark_len++;
                if (int'(is_dash) != mark_dash) viol++;
            end else if (is_dash) begin
                viol++;
            end
            if (!laser_on && laser_prev) begin
                if (exp_q.size() == 0) chk("unexpected_mark", K_MARK, -1);
                else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_kind"}, K_MARK, e.kind);
                    chk({e.name, "_mark_len"}, mark_len, e.len);
                    chk({e.name, "_is_dash"}, mark_dash, e.dash);
                    if (e.gap >= 0) chk({e.name, "_gap_before_mark"}, rise_gap, e.gap);
                end
                last_evt = cyc;
            end
            if (sym_done) begin
                if (exp_q.size() == 0) chk("unexpected_done", K_DONE, -1);
                else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_kind"}, K_DONE, e.kind);
                    if (e.gap >= 0) chk({e.name, "_gap_before_done"}, cyc - last_evt, e.gap);
                    chk({e.name, "_busy_at_done"}, int'(busy), 0);
                end
                last_done_cyc = cyc;
                last_evt = cyc;
            end
            if (busy && sym_if.ready) viol++;
            laser_prev = laser_on;
        end
    end

    // Offer a symbol and hold it until accepted
    task automatic send(input sym_t s, output int acc);
        logic r;
        acc = -1;
        sym_if.valid = 1'b1;
        sym_if.sym   = s;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            r = sym_if.ready;
            @(posedge clk);
            #1;
            if (r) begin
                acc = cyc;
                break;
            end
        end
        chk("accept_timeout", int'(acc >= 0), 1);
        if (acc >= 0) chk("busy_after_accept", int'(busy), 1);
        sym_if.valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            @(posedge clk);
            #1;
        end
        chk({name, "_drain_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_laser();
        int ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (laser_on) begin
                ok = 1;
                break;
            end
        end
        chk("laser_rise_timeout", ok, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int drop_cyc;
        reset_n = 1'b0;
        abort = 1'b0;
        sym_if.valid = 1'b0;
        sym_if.sym = mk(0, 0);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_laser_on", int'(laser_on), 0);
        chk("rst_is_dash", int'(is_dash), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sym_done", int'(sym_done), 0);
        chk("rst_sym_ready", int'(sym_if.ready), 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        chk("ready_after_release", int'(sym_if.ready), 1);

        // E, A, word space, E back to back with valid held
        push_mark(10, 0, -1, "E1");
        push_done(30, "E1");
        send(mk(1, 0), acc);
        push_mark(10, 0, 10, "A_dot");
        push_mark(30, 1, 10, "A_dash");
        push_done(30, "A");
        send(mk(2, 6'b000010), acc);
        chk("A_accept_after_done", acc, last_done_cyc + 1);
        push_done(50, "WORD");
        send(mk(0, 0), acc);
        chk("WORD_accept_after_done", acc, last_done_cyc + 1);
        push_mark(10, 0, 10, "E2");
        push_done(30, "E2");
        send(mk(1, 0), acc);
        chk("E2_accept_after_done", acc, last_done_cyc + 1);
        drain("seq");

        // Abort gates ready in IDLE
        @(posedge clk);
        #1;
        abort = 1'b1;
        #1;
        chk("ready_during_abort", int'(sym_if.ready), 0);
        abort = 1'b0;
        #1;
        chk("ready_after_abort_idle", int'(sym_if.ready), 1);

        // Abort mid-dash of T
        push_mark(15, 1, -1, "T_abort");
        send(mk(1, 1), acc);
        wait_laser();
        repeat (14) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        drop_cyc = cyc;
        chk("abort_laser_on", int'(laser_on), 0);
        chk("abort_is_dash", int'(is_dash), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_sym_done", int'(sym_done), 0);
        push_mark(10, 0, -1, "E_post_abort");
        push_done(30, "E_post_abort");
        send(mk(1, 0), acc);
        chk("accept_after_abort_drop", acc, drop_cyc + 1);
        drain("abort");

        // Reset mid-mark: laser drops without a clock edge
        push_mark(4, 1, -1, "T_reset");
        send(mk(1, 1), acc);
        wait_laser();
        repeat (4) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_laser_on", int'(laser_on), 0);
        chk("async_rst_is_dash", int'(is_dash), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_sym_done", int'(sym_done), 0);
        chk("async_rst_sym_ready", int'(sym_if.ready), 0);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        chk("ready_after_mid_release", int'(sym_if.ready), 1);

        // Length 7 clamps to six dots
        push_mark(10, 0, -1, "L7_e0");
        for (int i = 1; i < 6; i++) push_mark(10, 0, 10, $sformatf("L7_e%0d", i));
        push_done(30, "L7");
        send(mk(7, 0), acc);
        drain("clamp");

        chk("output_rule_violations", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/morse_symbol_sequencer.md
Name: morse_symbol_sequencer

Overview:
- Controller that sequences the laser/LED keying datapath one Morse symbol at a time.
- Accepts symbols (element count plus a dot/dash pattern) over a valid/ready handshake.
- Times each mark and gap in whole units using the one-cycle UNIT_TICK enable from the unit generator.
- Drives LASER_ON and IS_DASH. Sits between the message source and the laser/LED output pins, replacing free-running sentence playback.

Parameters:
- DASH_UNITS, 3: dash mark length in units (a dot is always 1 unit).
- ELEM_GAP_UNITS, 1: off time between elements of one symbol.
- CHAR_GAP_UNITS, 3: off time after the last element of a symbol.
- WORD_GAP_UNITS, 7: total word space. The word-space symbol adds WORD_GAP_UNITS-CHAR_GAP_UNITS.
- MAX_ELEMS, 6: maximum number of elements per symbol.
- CNT_W, 4: unit counter width. Must hold the largest duration.

Ports:
- CLK, input, 1: main clock (16 MHz).
- RESET_N, input, 1: asynchronous active-low reset.
- UNIT_TICK, input, 1: one-CLK-cycle pulse marking each unit boundary.
- SYM_VALID, input, 1: symbol offered.
- SYM_READY, output, 1: sequencer can accept a symbol.
- SYM_LEN, input, 3: element count 1..6; 0 = word space; 7 is clamped to 6.
- SYM_PATTERN, input, 6: bit i = 1 means element i is a dash. Element 0 is sent first (LSB first).
- ABORT, input, 1: synchronous flush.
- LASER_ON, output, 1: laser/LED drive.
- IS_DASH, output, 1: high while a dash mark is active.
- BUSY, output, 1: a symbol is in flight.
- SYM_DONE, output, 1: one-cycle pulse when a symbol completes, including its trailing gap.

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - State IDLE.
  - LASER_ON=0, IS_DASH=0, BUSY=0, SYM_DONE=0.
  - SYM_READY=0 while reset is asserted; 1 in the first cycle after release.
  - Counters and captured symbol cleared.
- All outputs are registered except SYM_READY, which is (state==IDLE) && !ABORT.
- Handshake:
  - A symbol is accepted on a CLK edge with SYM_VALID && SYM_READY. SYM_LEN and SYM_PATTERN are captured at that edge.
  - SYM_READY is low in all states except IDLE. The source holds its data until accepted.
- States:
  - IDLE: waits for accept, then goes to ARM. BUSY goes 1 the cycle after accept.
  - ARM: waits for the next UNIT_TICK, so every mark/gap is a whole number of units. A tick in the same cycle as the accept is not seen; ARM waits for the following tick. On the tick, goes to MARK (element 0), or to WORD if len==0.
  - MARK:
    - LASER_ON=1, and IS_DASH = pattern bit for the current element, both from the cycle after entry.
    - Lasts 1 unit (dot) or DASH_UNITS units (dash), counted in UNIT_TICKs.
    - On the final tick: if more elements remain, go to EGAP; otherwise go to CGAP.
    - LASER_ON and IS_DASH drop together on that transition.
  - EGAP: LASER_ON=0 for ELEM_GAP_UNITS ticks. Then MARK with the element index incremented.
  - CGAP: LASER_ON=0 for CHAR_GAP_UNITS ticks. Then IDLE, with SYM_DONE=1 for one cycle coincident with BUSY falling.
  - WORD: LASER_ON=0 for WORD_GAP_UNITS-CHAR_GAP_UNITS ticks (4). Then IDLE with SYM_DONE.
- Unit counter:
  - Cleared on every state entry, incremented on UNIT_TICK.
  - A state ends on the tick where count == duration-1.
  - The element index wraps never; it is bounded by the captured length.
- Back-to-back symbols:
  - A new symbol can be accepted in the first IDLE cycle after SYM_DONE. It then waits in ARM for the next tick.
  - The inter-symbol gap is therefore CHAR_GAP_UNITS plus up to one unit of ARM alignment.
- ABORT:
  - From any state, returns to IDLE on the next edge with LASER_ON=0, IS_DASH=0, BUSY=0.
  - No SYM_DONE is generated, and no accept occurs while ABORT is high.
- UNIT_TICK asserted on consecutive cycles counts each cycle as a unit. The source guarantees this does not happen at normal rates.
- Reset mid-symbol: the laser goes off immediately (asynchronously). The symbol is lost, with no SYM_DONE.

Decomposition:
- morse_pkg holds:
  - the state enum (IDLE, ARM, MARK, EGAP, CGAP, WORD);
  - default unit durations;
  - MAX_ELEMS;
  - the SYM_LEN encoding constant for word space (0).
- Optional sub-module morse_unit_timer: loadable duration, counts UNIT_TICKs, emits a one-cycle expire pulse. The FSM and symbol registers stay in the top module.

Test Plan:
- 'E' (len=1, pattern=0), UNIT_TICK every 10 CLK -> LASER_ON high exactly 10 CLK starting the cycle after the first tick, IS_DASH=0, then off 30 CLK, SYM_DONE pulse, BUSY 0.
- 'A' (len=2, pattern=6'b000010) -> on 10 CLK (IS_DASH=0), off 10, on 30 with IS_DASH=1, off 30, SYM_DONE.
- Word space (len=0) following 'E' -> LASER_ON stays 0. SYM_DONE 40 CLK after ARM's tick. Total off time between symbols = 7 units, ±1 unit of alignment.
- SYM_VALID held with two queued symbols -> second accepted in the first cycle after SYM_DONE. SYM_READY low throughout the first symbol.
- ABORT pulsed mid-dash of 'T' (len=1, pattern=1) -> LASER_ON/IS_DASH 0 next cycle, IDLE, no SYM_DONE. A new accept succeeds the cycle after ABORT drops.
- RESET_N low mid-mark -> LASER_ON 0 without waiting for a clock edge. All outputs at reset values. SYM_READY=1 in the first cycle after release.
